// File: rtl/stdout_uart_tx.sv
// Memory-mapped console: STDOUT writes feed a TX FIFO serialised as UART, HALT writes set a sticky flag.
// Optional even-parity framing is enabled with `define STDOUT_UART_PARITY_EN.
module stdout_uart_tx #(
  parameter int          FIFO_DEPTH   = 16,
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [23:0] ADDR_STDOUT  = 24'hFFFFFE,
  parameter logic [23:0] ADDR_HALT    = 24'hFFFFFF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clk_en,
  input  logic [23:0] i_addr,
  input  logic        i_wr,
  input  logic        i_rd,
  input  logic [31:0] i_din,
  output logic [31:0] o_dout,
  output logic        o_stall,
  output logic        o_txd,
  output logic        o_halt,
  output logic        o_busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
`ifdef STDOUT_UART_PARITY_EN
  localparam logic PARITY_FLAG = 1'b1;
`else
  localparam logic PARITY_FLAG = 1'b0;
`endif

`ifdef STDOUT_UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic          txd_q, txd_d;
  logic [7:0]    shreg_q, shreg_d;
`ifdef STDOUT_UART_PARITY_EN
  logic          par_q, par_d;
`endif
  logic          halt_q, ovf_q;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    mem [FIFO_DEPTH];

  logic sel_stdout, sel_halt, wr_stdout;
  logic full, empty, pop, push, blocked, tx_active;
  logic [31:0] status;
  logic unused_din;

  assign unused_din = ^i_din[31:8];

  assign sel_stdout = (i_addr == ADDR_STDOUT);
  assign sel_halt   = (i_addr == ADDR_HALT);
  assign wr_stdout  = i_wr & sel_stdout;
  assign full       = (cnt_q == DEPTH_C);
  assign empty      = (cnt_q == '0);
  assign tx_active  = (state_q != IDLE);

  // A pop on the same enabled cycle frees a slot, so a write to a full FIFO is accepted then.
  assign pop     = i_clk_en & (state_q == IDLE) & ~empty;
  assign push    = wr_stdout & i_clk_en & (~full | pop);
  assign blocked = wr_stdout & i_clk_en & full & ~pop;
  assign o_stall = wr_stdout & full & ~pop;

  assign status = {16'd0, 8'(cnt_q), 3'd0, PARITY_FLAG, ovf_q, tx_active, empty, full};
  assign o_dout = (i_rd && sel_stdout) ? status : 32'd0;
  assign o_txd  = txd_q;
  assign o_halt = halt_q;
  assign o_busy = ~empty | tx_active;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    txd_d   = txd_q;
    shreg_d = shreg_q;
`ifdef STDOUT_UART_PARITY_EN
    par_d   = par_q;
`endif
    if (baud_q != '0) baud_d = baud_q - BW'(1);
    case (state_q)
      IDLE: begin
        if (!empty) begin
          shreg_d = mem[rptr_q];
`ifdef STDOUT_UART_PARITY_EN
          par_d   = ^mem[rptr_q];
`endif
          txd_d   = 1'b0;
          baud_d  = BAUD_RELOAD;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == '0) begin
          txd_d   = shreg_q[0];
          shreg_d = {1'b0, shreg_q[7:1]};
          baud_d  = BAUD_RELOAD;
          bit_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (bit_q == 3'd7) begin
`ifdef STDOUT_UART_PARITY_EN
            txd_d   = par_q;
            state_d = PARITY;
`else
            txd_d   = 1'b1;
            state_d = STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            txd_d   = shreg_q[0];
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end
      end
`ifdef STDOUT_UART_PARITY_EN
      PARITY: begin
        if (baud_q == '0) begin
          txd_d   = 1'b1;
          baud_d  = BAUD_RELOAD;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: reset wins over the clock enable.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      txd_q   <= 1'b1;
      halt_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else if (i_clk_en) begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
      cnt_q   <= cnt_d;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop) rptr_q <= rptr_q + PW'(1);
      if (i_wr && sel_halt) halt_q <= 1'b1;
      if (blocked) ovf_q <= 1'b1;
    end
  end

  // Datapath storage carries no reset; stale contents are never observable.
  always_ff @(posedge i_clk) begin
    if (i_clk_en) begin
      if (push) mem[wptr_q] <= i_din[7:0];
      shreg_q <= shreg_d;
`ifdef STDOUT_UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
